// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: none, declarations only.
// Backpressure: not applicable.
package lsu_pkg;

   // funct3 encodings of the RV32 load/store access types
   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } ls_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // access width class; unlisted funct3 codes fall into word
   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } ls_size_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic ls_size_e ls_size(input logic [2:0] op);
      ls_size_e sz;
      case (op)
         LS_B, LS_BU: sz = SZ_B;
         LS_H, LS_HU: sz = SZ_H;
         default:     sz = SZ_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: picks the addressed byte/half lane and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  ls_op_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sext;

   // lane select, then extension chosen by access width and signedness
   always_comb begin
      case (lane_i)
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         2'd3:    byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      // halfword lane only looks at bit 1; bit 0 is either trapped or ignored upstream
      half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      sext     = ~ls_op_i[2];
      case (ls_size(ls_op_i))
         SZ_B:    data_o = {{24{sext & byte_sel[7]}}, byte_sel};
         SZ_H:    data_o = {{16{sext & half_sel[15]}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one req/ack data-bus transaction per load or store, load formatting.
// Latency: 3 cycles minimum (detect, busy, done), +1 per cycle of ack delay.
// Backpressure: stall_o holds the core until the bus acks; waits indefinitely. Option: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [2:0]        ls_op_i,
   input  logic              mem_wren_i,
   input  logic              mem_rden_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic [DATA_W-1:0] ld_data_o,
   output logic              stall_o,
   output logic              misaligned_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i
);

   logic              access;
   logic              mis_cond;
   logic              launch;
   ls_size_e          req_size;
   logic [3:0]        be_new;
   logic [DATA_W-1:0] wdata_new;
   logic [DATA_W-1:0] ld_fmt;

   lsu_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        lane_q, lane_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] ld_hold_q, ld_hold_d;

   // request decode: misalignment check, byte enables and lane-replicated store data
   always_comb begin
      access   = mem_wren_i | mem_rden_i;
      req_size = ls_size(ls_op_i);
`ifdef LSU_MISALIGN_TRAP_EN
      mis_cond = ((req_size == SZ_H) && addr_i[0]) ||
                 ((req_size == SZ_W) && (addr_i[1:0] != 2'b00));
`else
      mis_cond = 1'b0;
`endif
      launch = (state_q == ST_IDLE) && access && !mis_cond;
      case (req_size)
         SZ_B: begin
            be_new    = BE_BYTE << addr_i[1:0];
            wdata_new = {4{st_data_i[7:0]}};
         end
         SZ_H: begin
            be_new    = addr_i[1] ? (BE_HALF << 2) : BE_HALF;
            wdata_new = {2{st_data_i[15:0]}};
         end
         default: begin
            be_new    = BE_WORD;
            wdata_new = st_data_i;
         end
      endcase
   end

   // transaction FSM: launch from IDLE, wait for ack in BUSY, present load data in DONE
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      lane_d    = lane_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      op_d      = op_q;
      rdata_d   = rdata_q;
      ld_hold_d = ld_hold_q;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_BUSY;
               req_d   = 1'b1;
               // a store wins when both enables are raised together
               we_d    = mem_wren_i;
               addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
               lane_d  = addr_i[1:0];
               be_d    = be_new;
               wdata_d = wdata_new;
               op_d    = ls_op_i;
            end
         end
         ST_BUSY: begin
            if (bus_ack_i) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               rdata_d = bus_rdata_i;
            end
         end
         ST_DONE: begin
            // always leave DONE so the advancing instruction is never issued twice
            state_d = ST_IDLE;
            if (!we_q) begin
               ld_hold_d = ld_fmt;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and registered bus outputs; async reset abandons any outstanding request
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         lane_q    <= 2'b00;
         be_q      <= 4'b0000;
         wdata_q   <= '0;
         op_q      <= 3'b000;
         rdata_q   <= '0;
         ld_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         lane_q    <= lane_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         op_q      <= op_d;
         rdata_q   <= rdata_d;
         ld_hold_q <= ld_hold_d;
      end
   end

   lsu_load_align u_load_align (
      .rdata_i (rdata_q),
      .lane_i  (lane_q),
      .ls_op_i (op_q),
      .data_o  (ld_fmt)
   );

   assign bus_req_o    = req_q;
   assign bus_we_o     = we_q;
   assign bus_addr_o   = addr_q;
   assign bus_be_o     = be_q;
   assign bus_wdata_o  = wdata_q;
   // stall rises in the detect cycle itself so the PC never moves past the access
   assign stall_o      = launch || (state_q == ST_BUSY);
   assign misaligned_o = (state_q == ST_IDLE) && access && mis_cond;
   assign ld_data_o    = ((state_q == ST_DONE) && !we_q) ? ld_fmt : ld_hold_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [2:0]  ls_op_i = 3'b000;
   logic        mem_wren_i = 1'b0;
   logic        mem_rden_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] st_data_i = '0;
   logic [31:0] ld_data_o;
   logic        stall_o;
   logic        misaligned_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   always #5 clk_i = ~clk_i;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .ls_op_i      (ls_op_i),
      .mem_wren_i   (mem_wren_i),
      .mem_rden_i   (mem_rden_i),
      .addr_i       (addr_i),
      .st_data_i    (st_data_i),
      .ld_data_o    (ld_data_o),
      .stall_o      (stall_o),
      .misaligned_o (misaligned_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_be_o     (bus_be_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_ack_i    (bus_ack_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   typedef struct {
      bit          mis;
      bit          we;
      bit          ld;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld_val;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          ack_delay = 0;
   logic [31:0] rsp_rdata = '0;
   bit          spurious_en = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s at %0t", name, $time);
   endfunction

   // reference: access size, lane offset, enables, replication and extension by arithmetic
   function automatic exp_t model(input logic [2:0] op, input bit wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] rdata);
      exp_t        e;
      int          size;
      int          off;
      logic [31:0] mask;
      logic [31:0] v;
      size = (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
      e.mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      e.mis = (int'(a[1:0]) % size) != 0;
`endif
      off     = (size == 1) ? int'(a[1:0]) : (size == 2) ? (int'(a[1:0]) / 2) * 2 : 0;
      e.we    = wr;
      e.ld    = !wr;
      e.addr  = a & ~32'h3;
      e.be    = 4'(((1 << size) - 1) << off);
      e.wdata = (size == 1) ? (d & 32'hFF) * 32'h01010101 :
                (size == 2) ? (d & 32'hFFFF) * 32'h00010001 : d;
      mask    = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      v       = (rdata >> (8 * off)) & mask;
      if ((op == 3'd0 || op == 3'd1) && v[8 * size - 1]) v = v | ~mask;
      e.ld_val = v;
      return e;
   endfunction

   // bus slave: acks after ack_delay extra busy cycles, random stray acks when idle
   initial begin
      int cnt;
      cnt = 0;
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         bus_ack_i = 1'b0;
         bus_rdata_i = $urandom;
         if (rst_ni && bus_req_o) begin
            if (cnt >= ack_delay) begin
               bus_ack_i = 1'b1;
               bus_rdata_i = rsp_rdata;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            if (spurious_en && $urandom_range(0, 3) == 0) bus_ack_i = 1'b1;
         end
      end
   end

   // monitor: pops expectations on request launch / trap, tracks the held load value
   initial begin
      bit          prev_req;
      bit          have_cur;
      exp_t        cur;
      logic [31:0] model_ld;
      prev_req = 1'b0;
      have_cur = 1'b0;
      model_ld = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            prev_req = 1'b0;
            have_cur = 1'b0;
            model_ld = '0;
            continue;
         end
         if (bus_req_o && !prev_req) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_bus_req");
               have_cur = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               if (cur.mis) flag("bus_req_on_misaligned");
               check("bus_we", 32'(bus_we_o), 32'(cur.we));
               check("bus_addr", bus_addr_o, cur.addr);
               check("bus_be", 32'(bus_be_o), 32'(cur.be));
               if (cur.we) check("bus_wdata", bus_wdata_o, cur.wdata);
            end
         end else if (bus_req_o && have_cur) begin
            check("bus_addr_hold", bus_addr_o, cur.addr);
            check("bus_be_hold", 32'(bus_be_o), 32'(cur.be));
            check("bus_stall_hold", 32'(stall_o), 32'd1);
         end
         if (!bus_req_o && prev_req && have_cur) begin
            check("done_stall", 32'(stall_o), 32'd0);
            if (cur.ld) model_ld = cur.ld_val;
            have_cur = 1'b0;
         end
         if (misaligned_o) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_misaligned");
            end else begin
               cur = exp_q.pop_front();
               if (!cur.mis) flag("misaligned_on_aligned");
               check("mis_no_req", 32'(bus_req_o), 32'd0);
            end
         end
         check("ld_data", ld_data_o, model_ld);
         prev_req = bus_req_o;
      end
   end

   // drive one access starting just after a rising edge; returns just after a rising edge
   task automatic do_txn(input logic [2:0] op, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata, input int delay);
      exp_t e;
      int   n;
      e = model(op, wr, a, d, rdata);
      ack_delay = delay;
      rsp_rdata = rdata;
      exp_q.push_back(e);
      ls_op_i = op;
      mem_wren_i = wr;
      mem_rden_i = rd;
      addr_i = a;
      st_data_i = d;
      @(negedge clk_i);
      if (e.mis) begin
         check("mis_flag", 32'(misaligned_o), 32'd1);
         check("mis_stall", 32'(stall_o), 32'd0);
      end else begin
         n = 0;
         while (stall_o && n < 50) begin
            n++;
            @(negedge clk_i);
         end
         check("stall_cycles", n, 2 + delay);
      end
      @(posedge clk_i);
      #1;
      mem_wren_i = 1'b0;
      mem_rden_i = 1'b0;
      ls_op_i = 3'($urandom_range(0, 7));
      addr_i = $urandom;
      st_data_i = $urandom;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_i);
         check("idle_stall", 32'(stall_o), 32'd0);
         check("idle_mis", 32'(misaligned_o), 32'd0);
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_bus_req", 32'(bus_req_o), 32'd0);
      check("rst_bus_we", 32'(bus_we_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_mis", 32'(misaligned_o), 32'd0);
      check("rst_bus_addr", bus_addr_o, 32'd0);
      check("rst_bus_be", 32'(bus_be_o), 32'd0);
      check("rst_bus_wdata", bus_wdata_o, 32'd0);
      check("rst_ld_data", ld_data_o, 32'd0);
      rst_ni = 1'b1;
      idle(2);

      // directed accesses
      do_txn(3'b010, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
      do_txn(3'b000, 1, 0, 32'h203, 32'h000000A5, 32'h0, 0);
      do_txn(3'b000, 0, 1, 32'h301, 32'h0, 32'h12AB3456, 0);
      check("lb_pos_value", ld_data_o, 32'h00000034);
      do_txn(3'b000, 0, 1, 32'h301, 32'h0, 32'h1234F600, 2);
      check("lb_neg_value", ld_data_o, 32'hFFFFFFF6);
      do_txn(3'b100, 0, 1, 32'h301, 32'h0, 32'h1234F600, 0);
      check("lbu_value", ld_data_o, 32'h000000F6);
      do_txn(3'b001, 0, 1, 32'h402, 32'h0, 32'h80010000, 1);
      check("lh_value", ld_data_o, 32'hFFFF8001);
      do_txn(3'b101, 0, 1, 32'h402, 32'h0, 32'h80010000, 0);
      check("lhu_value", ld_data_o, 32'h00008001);
      do_txn(3'b010, 0, 1, 32'h501, 32'h0, 32'hCAFEF00D, 0);
      do_txn(3'b001, 1, 0, 32'h603, 32'h0000BEEF, 32'h0, 0);
      do_txn(3'b010, 1, 1, 32'h704, 32'h11223344, 32'h55, 0);
      do_txn(3'b110, 1, 0, 32'h802, 32'h89ABCDEF, 32'h0, 1);
      idle(1);

      // reset while a store waits for an ack that never comes
      ack_delay = 1000;
      e = model(3'b010, 1, 32'h900, 32'h0BADF00D, 32'h0);
      exp_q.push_back(e);
      ls_op_i = 3'b010;
      mem_wren_i = 1'b1;
      mem_rden_i = 1'b0;
      addr_i = 32'h900;
      st_data_i = 32'h0BADF00D;
      @(negedge clk_i);
      @(negedge clk_i);
      check("busy_req", 32'(bus_req_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      mem_wren_i = 1'b0;
      #1;
      check("async_req_drop", 32'(bus_req_o), 32'd0);
      check("async_stall_drop", 32'(stall_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle(1);
      do_txn(3'b010, 1, 0, 32'hA00, 32'h13579BDF, 32'h0, 0);

      // randomized traffic with stray acks between transactions
      spurious_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [1:0] sel;
         sel = 2'($urandom_range(1, 3));
         do_txn(3'($urandom_range(0, 7)), sel[0], sel[1], $urandom, $urandom, $urandom,
                $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
      end
      spurious_en = 1'b0;
      idle(2);
      if (exp_q.size() != 0) flag("expectations_left_over");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
